// File: rtl/ninjin_axi_pkg.sv
// ninjin_axi_pkg
// Shared AXI encodings and FSM state types for the ninjin AXI slave memory.
//   BURST_*  : AXI burst type encodings the slave understands
//   RESP_*   : AXI response encodings the slave produces
//   w_state_t / r_state_t : write / read channel FSM states
package ninjin_axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_t;

endpackage

// File: rtl/ninjin_s_axi_mem_ram.sv
// ninjin_s_axi_mem_ram
// Single-clock simple dual-port RAM: one byte-enabled write port and one
// registered, enabled read port. A read and a write to the same word in the
// same cycle return the old contents (read-first). Array contents are not
// reset; only the read output register is.
//   clk, xrst      : clock, async active-low reset (read register only)
//   we/waddr/wdata : byte write enables, word index, write data
//   re/raddr       : read enable, word index
//   rdata          : registered read data, held while re = 0
module ninjin_s_axi_mem_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int IDX_WIDTH  = 10
) (
    input  logic                    clk,
    input  logic                    xrst,
    input  logic [DATA_WIDTH/8-1:0] we,
    input  logic [IDX_WIDTH-1:0]    waddr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic                    re,
    input  logic [IDX_WIDTH-1:0]    raddr,
    output logic [DATA_WIDTH-1:0]   rdata
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int DEPTH = 1 << IDX_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (we[b]) begin
                mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    // Separate block so the output register can carry a reset while the
    // array stays a plain RAM; non-blocking semantics give read-first.
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/ninjin_s_axi_mem.sv
// ninjin_s_axi_mem
// AXI4 slave backed by an internal word-addressed RAM. One write burst and
// one read burst may be in flight at once (one per direction). Legal bursts
// are full-width FIXED or INCR; anything else is accepted beat-for-beat but
// does not touch the RAM and answers SLVERR (reads return zero data).
//   clk, xrst            : clock, async active-low reset
//   aw*/w*/b*            : AXI4 write address, write data, write response
//   ar*/r*               : AXI4 read address, read data
//
// state  | meaning
// W_IDLE | awready high, waiting for a write address
// W_DATA | wready high, writing beats into RAM
// W_RESP | bvalid high, waiting for bready
// R_IDLE | arready high, waiting for a read address
// R_DATA | rvalid high, streaming beats out of the RAM output register
module ninjin_s_axi_mem
    import ninjin_axi_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int ID_WIDTH   = 12
) (
    input  logic                    clk,
    input  logic                    xrst,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [ID_WIDTH-1:0]     awid,
    input  logic [DATA_WIDTH-1:0]   awaddr,
    input  logic [7:0]              awlen,
    input  logic [2:0]              awsize,
    input  logic [1:0]              awburst,
    input  logic                    wvalid,
    output logic                    wready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wlast,
    output logic                    bvalid,
    input  logic                    bready,
    output logic [ID_WIDTH-1:0]     bid,
    output logic [1:0]              bresp,
    input  logic                    arvalid,
    output logic                    arready,
    input  logic [ID_WIDTH-1:0]     arid,
    input  logic [DATA_WIDTH-1:0]   araddr,
    input  logic [7:0]              arlen,
    input  logic [2:0]              arsize,
    input  logic [1:0]              arburst,
    output logic                    rvalid,
    input  logic                    rready,
    output logic [ID_WIDTH-1:0]     rid,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rlast
);

    localparam int NB  = DATA_WIDTH / 8;
    localparam int OFF = $clog2(NB);
    localparam int IW  = ADDR_WIDTH - OFF;

    function automatic logic burst_ok(input logic [2:0] size, input logic [1:0] burst);
        return (size == 3'(OFF)) && !burst[1];
    endfunction

    // Only the word-index slice of each address is decoded.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{awaddr, araddr};

    // Holds both ready outputs low until the first clock after reset release.
    logic alive_q;

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) alive_q <= 1'b0;
        else       alive_q <= 1'b1;
    end

    // ---------------- write channel ----------------
    w_state_t              w_state, w_state_nx;
    logic [ID_WIDTH-1:0]   bid_q;
    logic [IW-1:0]         w_idx;
    logic [7:0]            w_rem;
    logic                  w_fixed;
    logic                  w_bad;
    logic                  w_over;
    logic [1:0]            bresp_q;
    logic                  aw_go;
    logic                  w_go;
    logic [NB-1:0]         ram_we;

    assign aw_go = (w_state == W_IDLE) && alive_q && awvalid;
    assign w_go  = (w_state == W_DATA) && wvalid;

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) w_state <= W_IDLE;
        else       w_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = w_state;
        awready    = 1'b0;
        wready     = 1'b0;
        bvalid     = 1'b0;
        case (w_state)
            W_IDLE: begin
                awready = alive_q;
                if (aw_go) w_state_nx = W_DATA;
            end
            W_DATA: begin
                wready = 1'b1;
                if (wvalid && wlast) w_state_nx = W_RESP;
            end
            W_RESP: begin
                bvalid = 1'b1;
                if (bready) w_state_nx = W_IDLE;
            end
            default: w_state_nx = W_IDLE;
        endcase
    end

    // w_rem counts beats remaining after the current one and saturates at 0;
    // a beat arriving at 0 without wlast marks an overrun.
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            bid_q   <= '0;
            w_idx   <= '0;
            w_rem   <= '0;
            w_fixed <= 1'b0;
            w_bad   <= 1'b0;
            w_over  <= 1'b0;
            bresp_q <= RESP_OKAY;
        end else if (aw_go) begin
            bid_q   <= awid;
            w_idx   <= awaddr[ADDR_WIDTH-1:OFF];
            w_rem   <= awlen;
            w_fixed <= (awburst == BURST_FIXED);
            w_bad   <= !burst_ok(awsize, awburst);
            w_over  <= 1'b0;
        end else if (w_go) begin
            if (!w_fixed)              w_idx  <= w_idx + 1'b1;
            if (w_rem != 8'd0)         w_rem  <= w_rem - 8'd1;
            if (w_rem == 8'd0 && !wlast) w_over <= 1'b1;
            if (wlast) begin
                bresp_q <= (w_bad || w_over || (w_rem != 8'd0)) ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

    assign ram_we = (w_go && !w_bad) ? wstrb : '0;
    assign bid    = bid_q;
    assign bresp  = bresp_q;

    // ---------------- read channel ----------------
    r_state_t              r_state, r_state_nx;
    logic [ID_WIDTH-1:0]   rid_q;
    logic [IW-1:0]         r_idx;
    logic [IW-1:0]         ar_idx;
    logic [7:0]            r_rem;
    logic                  r_fixed;
    logic                  r_err;
    logic                  rvalid_q;
    logic                  rlast_q;
    logic [1:0]            rresp_q;
    logic                  ar_go;
    logic                  r_adv;
    logic                  r_done;
    logic                  ram_re;
    logic [IW-1:0]         ram_raddr;
    logic [DATA_WIDTH-1:0] ram_q;

    assign ar_idx = araddr[ADDR_WIDTH-1:OFF];
    assign ar_go  = (r_state == R_IDLE) && alive_q && arvalid;
    assign r_adv  = (r_state == R_DATA) && rvalid_q && rready && !rlast_q;
    assign r_done = (r_state == R_DATA) && rvalid_q && rready && rlast_q;

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) r_state <= R_IDLE;
        else       r_state <= r_state_nx;
    end

    always_comb begin
        r_state_nx = r_state;
        arready    = 1'b0;
        case (r_state)
            R_IDLE: begin
                arready = alive_q;
                if (ar_go) r_state_nx = R_DATA;
            end
            R_DATA: begin
                if (r_done) r_state_nx = R_IDLE;
            end
            default: r_state_nx = R_IDLE;
        endcase
    end

    // r_idx always points at the next word to fetch; beat 0 is fetched
    // straight from araddr in the handshake cycle so it is valid one cycle later.
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            rid_q    <= '0;
            r_idx    <= '0;
            r_rem    <= '0;
            r_fixed  <= 1'b0;
            r_err    <= 1'b0;
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
            rresp_q  <= RESP_OKAY;
        end else if (ar_go) begin
            rid_q    <= arid;
            r_idx    <= (arburst == BURST_FIXED) ? ar_idx : ar_idx + 1'b1;
            r_rem    <= arlen;
            r_fixed  <= (arburst == BURST_FIXED);
            r_err    <= !burst_ok(arsize, arburst);
            rvalid_q <= 1'b1;
            rlast_q  <= (arlen == 8'd0);
            rresp_q  <= burst_ok(arsize, arburst) ? RESP_OKAY : RESP_SLVERR;
        end else if (r_adv) begin
            if (!r_fixed) r_idx <= r_idx + 1'b1;
            r_rem   <= r_rem - 8'd1;
            rlast_q <= (r_rem == 8'd1);
        end else if (r_done) begin
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
        end
    end

    assign ram_re    = ar_go || r_adv;
    assign ram_raddr = ar_go ? ar_idx : r_idx;

    assign rvalid = rvalid_q;
    assign rlast  = rlast_q;
    assign rid    = rid_q;
    assign rresp  = rresp_q;
    assign rdata  = r_err ? '0 : ram_q;

    ninjin_s_axi_mem_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_WIDTH  (IW)
    ) u_ram (
        .clk   (clk),
        .xrst  (xrst),
        .we    (ram_we),
        .waddr (w_idx),
        .wdata (wdata),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (ram_q)
    );

endmodule

// File: doc/ninjin_s_axi_mem.md
# ninjin_s_axi_mem

AXI4 full-protocol slave backed by an internal word-addressed RAM: the responder end of the ninjin AXI master interface (AW/W/B/AR/R). It accepts one write burst and one read burst concurrently, one outstanding per direction, and is the DDR stand-in for loopback and regression of the ninjin masters.

## Interface
Parameters:
- DATA_WIDTH, 32, data bus width; power of two, ≥ 8.
- ADDR_WIDTH, 12, byte address bits decoded; memory is 2^ADDR_WIDTH bytes.
- ID_WIDTH, 12, AXI ID width.

Ports (all inputs and outputs use the AXI4 names and meanings unless stated otherwise):
- Reset convention (already decided): one clock; reset is asynchronous and active-low.
- clk  in  1  clock.
- xrst  in  1  asynchronous active-low reset.
- awvalid/awready  in/out  1  write address handshake.
- awid  in  ID_WIDTH.
- awaddr  in  DATA_WIDTH  byte address; bits ≥ ADDR_WIDTH ignored.
- awlen  in  8.
- awsize  in  3.
- awburst  in  2.
- wvalid/wready  in/out  1.
- wdata  in  DATA_WIDTH.
- wstrb  in  DATA_WIDTH/8  byte enables.
- wlast  in  1.
- bvalid/bready  out/in  1.
- bid  out  ID_WIDTH.
- bresp  out  2.
- arvalid/arready  in/out  1.
- arid  in  ID_WIDTH.
- araddr  in  DATA_WIDTH.
- arlen  in  8.
- arsize  in  3.
- arburst  in  2.
- rvalid/rready  out/in  1.
- rid  out  ID_WIDTH.
- rdata  out  DATA_WIDTH.
- rresp  out  2.
- rlast  out  1.
- awlock/awcache/awprot/awqos/awuser and the ar* equivalents are not ported; masters leave them unconnected.

## Operation
- Word index = addr[ADDR_WIDTH-1 : log2(DATA_WIDTH/8)]. Low bits are ignored; unaligned starts are treated as aligned.
- Burst legal iff size == log2(DATA_WIDTH/8) and burst ∈ {FIXED=00, INCR=01}.
  - FIXED holds the index.
  - INCR increments the index by 1 per beat, wrapping modulo memory depth with no error.
  - Illegal burst: all beats accepted, no RAM write, response SLVERR; read beats return rdata = 0.
- Write FSM: W_IDLE → W_DATA → W_RESP → W_IDLE.
  - W_IDLE: awready = 1. On the AW handshake, latch id, index, len, burst and the error flag.
  - W_DATA: wready = 1. Each W handshake writes the bytes enabled by wstrb, then advances the index and the beat counter.
  - Leave W_DATA on a handshake with wlast = 1. If wlast arrives on a beat ≠ awlen, respond SLVERR; beats past awlen are still written.
  - W_RESP: bvalid = 1 with bid = latched id and bresp ∈ {00 OKAY, 10 SLVERR}. Hold until bready, then go to W_IDLE.
- Read FSM: R_IDLE → R_DATA → R_IDLE.
  - R_IDLE: arready = 1. On the AR handshake, latch the burst and go to R_DATA.
  - R_DATA: rdata is a RAM output register, loaded when (!rvalid || rready) and beats remain.
  - rlast = 1 on beat arlen. rid = latched id. rresp = 00 for a legal burst, 10 for an illegal one.
  - After the rlast handshake go to R_IDLE.
- Same-word write and read in one cycle: read-first; the read returns the old data.
- RAM contents are not reset.

## Timing
- Reset values: awready = arready = wready = bvalid = rvalid = rlast = 0; bid = rid = 0; bresp = rresp = 0; rdata = 0. FSMs start in IDLE.
- awready and arready rise in the first clk edge after xrst deasserts.
- Write latency:
  - AW handshake at cycle T → wready = 1 at T+1.
  - Last W handshake at T → bvalid = 1 at T+1.
  - Next awready at the cycle after the B handshake.
- Read latency:
  - AR handshake at T → rvalid = 1 with beat 0 at T+1.
  - With rready held high, one beat per cycle. With rready low, rdata/rlast/rresp are held stable.
  - arready = 0 from T+1 until the cycle after the rlast handshake.
- Write and read channels are fully independent; simultaneous AW and AR handshakes are both accepted.
- xrst asserted mid-burst aborts both bursts immediately; all outputs return to reset values. A partially written burst remains in RAM.

## Structure
- ninjin_axi_pkg: BURST_FIXED/BURST_INCR, RESP_OKAY/RESP_SLVERR, and the write/read FSM state enums.
- Sub-module ninjin_s_axi_mem_ram: single-clock simple dual-port RAM with byte write enables and a registered, enabled read port, read-first. Depth 2^(ADDR_WIDTH-log2(DATA_WIDTH/8)).

## Test plan
- Write then read, INCR len=255, addr 0, data 0..255, ready always high:
  - bresp = 00, bid = awid.
  - Read returns 0..255 on consecutive cycles, rlast only on beat 255.
- Read with rready toggled randomly: data sequence unchanged, outputs stable while stalled, no dropped or duplicated beat.
- Write wstrb = 4'b0101 data 0xAABBCCDD over 0xFFFFFFFF, then read: returns 0xFFBBFFDD.
- awburst = 10 (WRAP) with 4 beats: bresp = 10 and memory unchanged. FIXED 4-beat write 1,2,3,4: the word reads back 4.
- wlast on beat 2 of an awlen = 3 burst: bresp = 10. Concurrent read and write to the same word: read-first value returned.
- xrst pulsed during R_DATA beat 10: rvalid = 0 immediately; a new AR after reset completes normally.
